// File: rtl/adc_osr_pkg.sv
// Shared mode encoding and helpers for the multi-channel oversampling decimator.
package adc_osr_pkg;

  localparam logic [2:0] OSR_BYPASS = 3'd0;
  localparam logic [2:0] OSR_4      = 3'd1;
  localparam logic [2:0] OSR_16     = 3'd2;
  localparam logic [2:0] OSR_64     = 3'd3;
  localparam logic [2:0] OSR_256    = 3'd4;

  function automatic int osr_samples(input logic [2:0] k);
    return 1 << (2 * int'(k));
  endfunction

  function automatic logic [2:0] clamp_k(input logic [2:0] k, input int max_k);
    return (int'(k) > max_k) ? 3'(max_k) : k;
  endfunction

endpackage

// File: rtl/adc_osr_fifo.sv
// First-word-fall-through result FIFO; a pop on a full FIFO frees room for a same-edge push.
module adc_osr_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Head reads as zero when empty so the output bus is quiet after reset.
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/adc_osr_mc.sv
// Multi-channel oversampling decimator: per-channel accumulate 4^k samples, emit sum>>k.
module adc_osr_mc
  import adc_osr_pkg::*;
#(
  parameter int DATA_W     = 10,
  parameter int OUT_W      = 16,
  parameter int NUM_CH     = 4,
  parameter int MAX_K      = 4,
  parameter int FIFO_DEPTH = 4,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic [CH_W-1:0]   sample_ch,
  input  logic [DATA_W-1:0] sample_data,
  input  logic [2:0]        osr_mode,
  input  logic              clr_status,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH_W-1:0]   out_ch,
  output logic [OUT_W-1:0]  out_data,
  output logic [LVL_W-1:0]  fifo_level,
  output logic              overflow,
  output logic              ch_err
);

  localparam int ACC_W = DATA_W + 2 * MAX_K;
  localparam int CNT_W = 2 * MAX_K;

  logic [ACC_W-1:0] acc [NUM_CH];
  logic [CNT_W-1:0] cnt [NUM_CH];
  logic [2:0]       mode_q;
  logic [2:0]       k_cur;
  logic             mode_chg;
  logic             ch_ok;
  logic             smp_ok;
  logic             last;
  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic             fifo_full;
  logic [ACC_W-1:0] sum;
  logic [OUT_W-1:0] result;

  function automatic logic [OUT_W-1:0] decimate(input logic [ACC_W-1:0] s, input logic [2:0] k);
    logic [ACC_W-1:0] sh;
    sh = s >> k;
    return OUT_W'(sh);
  endfunction

  assign k_cur    = clamp_k(osr_mode, MAX_K);
  assign mode_chg = (k_cur != mode_q);
  assign ch_ok    = (int'(sample_ch) < NUM_CH);
  // A sample coinciding with a mode switch is dropped along with all partial sums.
  assign smp_ok   = sample_valid && ch_ok && !mode_chg;
  assign sum      = acc[sample_ch] + ACC_W'(sample_data);
  assign last     = (cnt[sample_ch] == CNT_W'(osr_samples(mode_q) - 1));
  assign result   = decimate(sum, mode_q);
  assign push     = smp_ok && last;
  assign out_valid = !fifo_empty;
  assign pop      = out_valid && out_ready;

  adc_osr_fifo #(
    .WIDTH (CH_W + OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({sample_ch, result}),
    .pop   (pop),
    .dout  ({out_ch, out_data}),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (fifo_level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q   <= OSR_BYPASS;
      overflow <= 1'b0;
      ch_err   <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        acc[c] <= '0;
        cnt[c] <= '0;
      end
    end else begin
      mode_q <= k_cur;
      if (mode_chg) begin
        for (int c = 0; c < NUM_CH; c++) begin
          acc[c] <= '0;
          cnt[c] <= '0;
        end
      end else if (smp_ok) begin
        if (last) begin
          acc[sample_ch] <= '0;
          cnt[sample_ch] <= '0;
        end else begin
          acc[sample_ch] <= sum;
          cnt[sample_ch] <= cnt[sample_ch] + CNT_W'(1);
        end
      end
      // Clear first so a same-cycle error event wins.
      if (clr_status) begin
        overflow <= 1'b0;
        ch_err   <= 1'b0;
      end
      if (sample_valid && !ch_ok)       ch_err   <= 1'b1;
      if (push && fifo_full && !pop)    overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adc_osr_mc.sv
// Directed bench for adc_osr_mc with hand-computed decimation results.
module tb_adc_osr_mc;

  localparam int DATA_W     = 10;
  localparam int OUT_W      = 16;
  localparam int NUM_CH     = 3;
  localparam int MAX_K      = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int CH_W       = 2;
  localparam int LVL_W      = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              sample_valid = 1'b0;
  logic [CH_W-1:0]   sample_ch = '0;
  logic [DATA_W-1:0] sample_data = '0;
  logic [2:0]        osr_mode = 3'd0;
  logic              clr_status = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [CH_W-1:0]   out_ch;
  logic [OUT_W-1:0]  out_data;
  logic [LVL_W-1:0]  fifo_level;
  logic              overflow;
  logic              ch_err;

  int total = 0;
  int bad   = 0;

  adc_osr_mc #(
    .DATA_W     (DATA_W),
    .OUT_W      (OUT_W),
    .NUM_CH     (NUM_CH),
    .MAX_K      (MAX_K),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample_ch    (sample_ch),
    .sample_data  (sample_data),
    .osr_mode     (osr_mode),
    .clr_status   (clr_status),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_ch       (out_ch),
    .out_data     (out_data),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .ch_err       (ch_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mode(input logic [2:0] k);
    osr_mode = k;
    tick();
  endtask

  task automatic send(input int ch, input int data);
    sample_valid = 1'b1;
    sample_ch    = CH_W'(ch);
    sample_data  = DATA_W'(data);
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [31:0] ch, input logic [31:0] data);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_vld"}, 32'(out_valid), 32'd1);
    check({tag, "_ch"}, 32'(out_ch), ch);
    check({tag, "_data"}, 32'(out_data), data);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    check("rst_vld", 32'(out_valid), 32'd0);
    check("rst_ch", 32'(out_ch), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_lvl", 32'(fifo_level), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_cherr", 32'(ch_err), 32'd0);
    rst = 1'b0;
    tick();

    // k=1 single result with out_ready held high
    set_mode(3'd1);
    out_ready = 1'b1;
    send(0, 0);
    send(0, 1);
    send(0, 2);
    check("t1_vld_early", 32'(out_valid), 32'd0);
    send(0, 3);
    check("t1_vld", 32'(out_valid), 32'd1);
    check("t1_ch", 32'(out_ch), 32'd0);
    check("t1_data", 32'(out_data), 32'h0003);
    tick();
    check("t1_popped", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // deeper ratios
    set_mode(3'd2);
    for (int i = 0; i < 16; i++) send(1, 'h090);
    pop_expect("t2_k2", 32'd1, 32'h0240);
    set_mode(3'd3);
    for (int i = 0; i < 64; i++) send(0, i);
    pop_expect("t2_k3", 32'd0, 32'h00FC);
    set_mode(3'd5);
    for (int i = 0; i < 256; i++) send(2, i);
    pop_expect("t2_k4clamp", 32'd2, 32'h07F8);

    // interleaved channels, completion order
    set_mode(3'd1);
    for (int i = 0; i < 4; i++) begin
      send(0, 'h3FF);
      send(1, 'h000);
    end
    check("t3_lvl", 32'(fifo_level), 32'd2);
    pop_expect("t3_first", 32'd0, 32'h07FE);
    pop_expect("t3_second", 32'd1, 32'h0000);

    // bypass, overflow, same-edge push/pop at full
    set_mode(3'd0);
    for (int i = 1; i <= 5; i++) send(0, 'h100 + i);
    check("t4_lvl_full", 32'(fifo_level), 32'd4);
    check("t4_ovf", 32'(overflow), 32'd1);
    check("t4_head_hold", 32'(out_data), 32'h0101);
    pulse_clr();
    check("t4_ovf_clr", 32'(overflow), 32'd0);
    out_ready = 1'b1;
    send(0, 'h106);
    out_ready = 1'b0;
    check("t4_lvl_pushpop", 32'(fifo_level), 32'd4);
    check("t4_ovf_pushpop", 32'(overflow), 32'd0);
    pop_expect("t4_d2", 32'd0, 32'h0102);
    pop_expect("t4_d3", 32'd0, 32'h0103);
    pop_expect("t4_d4", 32'd0, 32'h0104);
    pop_expect("t4_d6", 32'd0, 32'h0106);
    check("t4_empty", 32'(fifo_level), 32'd0);

    // mode change discards partial sum
    set_mode(3'd1);
    send(0, 'h010);
    send(0, 'h020);
    set_mode(3'd0);
    check("t5_no_partial", 32'(out_valid), 32'd0);
    send(0, 'h055);
    pop_expect("t5_bypass", 32'd0, 32'h0055);

    // invalid channel and sticky-flag priority
    send(NUM_CH, 'h3FF);
    check("t6_cherr", 32'(ch_err), 32'd1);
    check("t6_cherr_noout", 32'(out_valid), 32'd0);
    clr_status = 1'b1;
    send(NUM_CH, 'h001);
    clr_status = 1'b0;
    check("t6_set_wins", 32'(ch_err), 32'd1);
    pulse_clr();
    check("t6_cherr_clr", 32'(ch_err), 32'd0);

    // asynchronous reset mid-accumulation
    set_mode(3'd1);
    for (int i = 0; i < 4; i++) send(1, 1);
    send(0, 'h200);
    send(0, 'h200);
    check("t6_pre_lvl", 32'(fifo_level), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_arst_vld", 32'(out_valid), 32'd0);
    check("t6_arst_data", 32'(out_data), 32'd0);
    check("t6_arst_lvl", 32'(fifo_level), 32'd0);
    tick();
    rst = 1'b0;
    set_mode(3'd1);
    send(0, 4);
    send(0, 5);
    send(0, 6);
    send(0, 7);
    pop_expect("t6_fresh", 32'd0, 32'h000B);
    check("t6_final_lvl", 32'(fifo_level), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
